prog_timer_ctrl: RTL and testbench

//  Sequencing controller around an up-counter: start/stop control, programmable

---
 rtl/prog_timer_ctrl_if.sv | 27 ++
 rtl/prog_timer_ctrl.sv | 138 +++++++++++++
 tb/tb_prog_timer_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_timer_ctrl_if.sv
// Control/status bundle for prog_timer_ctrl.
// master: issues start/stop and the run configuration, observes count/status.
// slave : the timer itself; all outputs it drives are registered.
interface prog_timer_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int PRE_W = 4
);
   logic             start;
   logic             stop;
   logic             mode;
   logic [WIDTH-1:0] load_val;
   logic [PRE_W-1:0] prescale;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
   logic             tick;

   modport master (
      output start, stop, mode, load_val, prescale,
      input  count, busy, done, tick
   );

   modport slave (
      input  start, stop, mode, load_val, prescale,
      output count, busy, done, tick
   );
endinterface

// File: rtl/prog_timer_ctrl.sv
// Programmable up-counting timer controller with prescaler, one-shot or
// auto-reload mode, single-cycle terminal tick and busy/done status.
// Ports: clk, rst (async, active-low), bus (slave side of prog_timer_ctrl_if:
//   start/stop/mode/load_val/prescale in; count/busy/done/tick out).
// Latency: start sampled on edge E0 -> busy after E0; terminal step lands on
//   edge E0+(L+1)*(P+1). No backpressure; stop dominates start and the tick.
module prog_timer_ctrl #(
   parameter int WIDTH = 8,
   parameter int PRE_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   prog_timer_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q,    state_d;
   logic [WIDTH-1:0] count_q,    count_d;
   logic [PRE_W-1:0] pre_cnt_q,  pre_cnt_d;
   logic             tick_q,     tick_d;
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;

   // Shadow copies of the run configuration; only rewritten at a start.
   logic             mode_q,     mode_d;
   logic [WIDTH-1:0] limit_q,    limit_d;
   logic [PRE_W-1:0] prescale_q, prescale_d;

   logic             step;
   logic             at_limit;

   assign step     = (pre_cnt_q == prescale_q);
   assign at_limit = (count_q == limit_q);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      pre_cnt_d  = pre_cnt_q;
      tick_d     = 1'b0;
      mode_d     = mode_q;
      limit_d    = limit_q;
      prescale_d = prescale_q;

      if (bus.stop) begin
         // Abort beats a coincident terminal step and any start.
         state_d   = ST_IDLE;
         count_d   = '0;
         pre_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               // DONE restarts exactly like IDLE, relatching the config.
               if (bus.start) begin
                  state_d    = ST_RUN;
                  count_d    = '0;
                  pre_cnt_d  = '0;
                  mode_d     = bus.mode;
                  limit_d    = bus.load_val;
                  prescale_d = bus.prescale;
               end
            end
            ST_RUN: begin
               // start is deliberately ignored here: no restart, no relatch.
               if (step) begin
                  pre_cnt_d = '0;
                  if (!at_limit) begin
                     count_d = count_q + WIDTH'(1);
                  end else begin
                     tick_d = 1'b1;
                     if (mode_q) begin
                        count_d = '0;
                     end else begin
                        state_d = ST_DONE;   // count holds limit_q
                     end
                  end
               end else begin
                  pre_cnt_d = pre_cnt_q + PRE_W'(1);
               end
            end
            default: begin
               state_d   = ST_IDLE;
               count_d   = '0;
               pre_cnt_d = '0;
            end
         endcase
      end

      // Status flags decoded from the next state so they are flop outputs.
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         pre_cnt_q  <= '0;
         tick_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mode_q     <= 1'b0;
         limit_q    <= '0;
         prescale_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         pre_cnt_q  <= pre_cnt_d;
         tick_q     <= tick_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         mode_q     <= mode_d;
         limit_q    <= limit_d;
         prescale_q <= prescale_d;
      end
   end

   assign bus.count = count_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.tick  = tick_q;

`ifndef SYNTHESIS
   // RUN and DONE are exclusive, and a tick is only ever followed by RUN
   // (periodic) or DONE (one-shot) since stop suppresses it.
   a_status_exclusive : assert property (@(posedge clk) disable iff (!rst)
      !(busy_q && done_q));
   a_tick_state : assert property (@(posedge clk) disable iff (!rst)
      tick_q |-> (busy_q || done_q));
   a_prescale_bound : assert property (@(posedge clk) disable iff (!rst)
      (state_q == ST_RUN) |-> (pre_cnt_q <= prescale_q));
`endif

endmodule

// File: tb/tb_prog_timer_ctrl.sv
module tb_prog_timer_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   prog_timer_ctrl_if #(.WIDTH(8), .PRE_W(4)) bus ();
   prog_timer_ctrl #(.WIDTH(8), .PRE_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Packed observation: {count, busy, done, tick}
   function automatic logic [10:0] obs();
      return {bus.count, bus.busy, bus.done, bus.tick};
   endfunction

   task automatic idle_inputs();
      bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
      bus.load_val = '0; bus.prescale = '0;
   endtask

   // Start a run; returns just after edge E0.
   task automatic go(input logic m, input logic [7:0] l, input logic [3:0] p);
      bus.mode = m; bus.load_val = l; bus.prescale = p; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic abort();
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] e;
      idle_inputs();
      rst = 1'b0;
      step(2);
      e = '0;
      total_cnt++;
      if (obs() !== e) $display("FAIL reset_hold got=%h want=%h", obs(), e);
      else pass_cnt++;
      rst = 1'b1;
      step(2);
      total_cnt++;
      if (obs() !== e) $display("FAIL reset_release got=%h want=%h", obs(), e);
      else pass_cnt++;
   endtask

   task automatic test_one_shot();
      logic [10:0] e;
      logic [7:0]  ec;
      go(1'b0, 8'd3, 4'd0);
      for (int k = 0; k <= 6; k++) begin
         ec = (k <= 3) ? 8'(k) : 8'd3;
         e  = {ec, 1'(k < 4), 1'(k >= 4), 1'(k == 4)};
         total_cnt++;
         if (obs() !== e) $display("FAIL one_shot k=%0d got=%h want=%h", k, obs(), e);
         else pass_cnt++;
         step();
      end
      abort();
   endtask

   task automatic test_periodic();
      logic [10:0] e;
      go(1'b1, 8'd2, 4'd1);
      for (int k = 0; k <= 18; k++) begin
         e = {8'((k % 6) / 2), 1'b1, 1'b0, 1'(k > 0 && k % 6 == 0)};
         total_cnt++;
         if (obs() !== e) $display("FAIL periodic k=%0d got=%h want=%h", k, obs(), e);
         else pass_cnt++;
         step();
      end
      abort();
   endtask

   task automatic test_extremes();
      logic [10:0] e;
      go(1'b1, 8'd0, 4'd0);
      for (int k = 0; k <= 5; k++) begin
         e = {8'd0, 1'b1, 1'b0, 1'(k > 0)};
         total_cnt++;
         if (obs() !== e) $display("FAIL fast_tick k=%0d got=%h want=%h", k, obs(), e);
         else pass_cnt++;
         step();
      end
      abort();
      go(1'b1, 8'd255, 4'd0);
      for (int k = 0; k <= 257; k++) begin
         e = {8'(k % 256), 1'b1, 1'b0, 1'(k == 256)};
         total_cnt++;
         if (obs() !== e) $display("FAIL full_range k=%0d got=%h want=%h", k, obs(), e);
         else pass_cnt++;
         step();
      end
      abort();
   endtask

   task automatic test_stop_priority();
      logic [10:0] e;
      e = '0;
      go(1'b0, 8'd3, 4'd0);
      step(3);
      bus.stop = 1'b1;                 // sampled on the terminal-step edge
      step();
      bus.stop = 1'b0;
      total_cnt++;
      if (obs() !== e) $display("FAIL stop_at_terminal got=%h want=%h", obs(), e);
      else pass_cnt++;
      step();
      total_cnt++;
      if (obs() !== e) $display("FAIL stop_no_late_tick got=%h want=%h", obs(), e);
      else pass_cnt++;
      bus.start = 1'b1; bus.stop = 1'b1;
      step();
      total_cnt++;
      if (obs() !== e) $display("FAIL stop_start_idle got=%h want=%h", obs(), e);
      else pass_cnt++;
      bus.start = 1'b0; bus.stop = 1'b0;
      step();
      total_cnt++;
      if (obs() !== e) $display("FAIL stop_start_after got=%h want=%h", obs(), e);
      else pass_cnt++;
   endtask

   task automatic test_live_change();
      logic [10:0] e;
      go(1'b0, 8'd3, 4'd0);
      step();
      bus.load_val = 8'd7; bus.prescale = 4'd2; bus.mode = 1'b1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      e = {8'd2, 1'b1, 1'b0, 1'b0};
      total_cnt++;
      if (obs() !== e) $display("FAIL live_k2 got=%h want=%h", obs(), e);
      else pass_cnt++;
      step();
      e = {8'd3, 1'b1, 1'b0, 1'b0};
      total_cnt++;
      if (obs() !== e) $display("FAIL live_k3 got=%h want=%h", obs(), e);
      else pass_cnt++;
      step();
      e = {8'd3, 1'b0, 1'b1, 1'b1};
      total_cnt++;
      if (obs() !== e) $display("FAIL live_terminal got=%h want=%h", obs(), e);
      else pass_cnt++;
      step();
      e = {8'd3, 1'b0, 1'b1, 1'b0};
      total_cnt++;
      if (obs() !== e) $display("FAIL live_done_hold got=%h want=%h", obs(), e);
      else pass_cnt++;
      // Restart from DONE with a new configuration.
      go(1'b1, 8'd1, 4'd1);
      for (int k = 0; k <= 8; k++) begin
         e = {8'((k % 4) / 2), 1'b1, 1'b0, 1'(k > 0 && k % 4 == 0)};
         total_cnt++;
         if (obs() !== e) $display("FAIL relatch k=%0d got=%h want=%h", k, obs(), e);
         else pass_cnt++;
         step();
      end
      abort();
   endtask

   task automatic test_async_reset();
      logic [10:0] e;
      go(1'b0, 8'd5, 4'd0);
      step(2);
      e = {8'd2, 1'b1, 1'b0, 1'b0};
      total_cnt++;
      if (obs() !== e) $display("FAIL arst_pre got=%h want=%h", obs(), e);
      else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      e = '0;
      total_cnt++;
      if (obs() !== e) $display("FAIL arst_immediate got=%h want=%h", obs(), e);
      else pass_cnt++;
      step(2);
      #2 rst = 1'b1;
      step(6);
      total_cnt++;
      if (obs() !== e) $display("FAIL arst_stays_idle got=%h want=%h", obs(), e);
      else pass_cnt++;
      go(1'b0, 8'd1, 4'd0);
      e = {8'd0, 1'b1, 1'b0, 1'b0};
      total_cnt++;
      if (obs() !== e) $display("FAIL arst_restart got=%h want=%h", obs(), e);
      else pass_cnt++;
      abort();
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_periodic();
      test_extremes();
      test_stop_priority();
      test_live_change();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
